// File: rtl/pw_feature_streamer_if.sv
// Pixel/word stream bundle for pw_feature_streamer.
// PW_STREAMER_LAST_EN adds the last_out/frame_last_out markers.
interface pw_feature_streamer_if #(
  parameter int N           = 16,
  parameter int IN_CHANNELS = 16
);
  localparam int CW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  logic [IN_CHANNELS*N-1:0] pixel_in;
  logic                     pixel_valid;
  logic                     pixel_ready;
  logic                     stall_in;
  logic [N-1:0]             data_out;
  logic [CW-1:0]            channel_out;
  logic                     valid_out;
`ifdef PW_STREAMER_LAST_EN
  logic                     last_out;
  logic                     frame_last_out;

  modport master (
    output pixel_in, pixel_valid, stall_in,
    input  pixel_ready, data_out, channel_out, valid_out, last_out, frame_last_out
  );
  modport slave (
    input  pixel_in, pixel_valid, stall_in,
    output pixel_ready, data_out, channel_out, valid_out, last_out, frame_last_out
  );
`else
  modport master (
    output pixel_in, pixel_valid, stall_in,
    input  pixel_ready, data_out, channel_out, valid_out
  );
  modport slave (
    input  pixel_in, pixel_valid, stall_in,
    output pixel_ready, data_out, channel_out, valid_out
  );
`endif
endinterface

// File: rtl/pw_feature_streamer.sv
// Pixel-to-channel-word serializer with a two-slot ping-pong pixel buffer.
// Optional PW_STREAMER_LAST_EN adds per-pixel and per-frame last markers.
module pw_feature_streamer #(
  parameter int N            = 16,
  parameter int IN_CHANNELS  = 16,
  parameter int FEATURE_SIZE = 112,
  parameter int REPEAT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  pw_feature_streamer_if.slave  bus,
  output logic                  busy,
  output logic                  done
);
  localparam int CW     = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int PIXELS = FEATURE_SIZE * FEATURE_SIZE;
  localparam int FW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int RW     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(IN_CHANNELS - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [FW-1:0] PIX_LAST = FW'(PIXELS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   r_state;
  logic [IN_CHANNELS*N-1:0] r_buf [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_occ;
  logic [CW-1:0]            r_ch;
  logic [RW-1:0]            r_rep;
  logic [FW-1:0]            r_frame;
  logic                     r_finish;
  logic                     r_pixel_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;
  logic [N-1:0]             r_data;
  logic [CW-1:0]            r_channel;

  logic                     w_accept;
  logic                     w_emit;
  logic                     w_word_last;
  logic                     w_release;
  logic [1:0]               w_occ_next;
  state_t                   w_state_next;
  logic [N-1:0]             w_word [IN_CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < IN_CHANNELS; gi++) begin : g_word
      assign w_word[gi] = r_buf[r_rd_ptr][gi*N +: N];
    end
  endgenerate

  // r_finish marks the gap cycle after the frame's final word; nothing is emitted then.
  always_comb begin
    w_accept     = bus.pixel_valid && r_pixel_ready;
    w_emit       = (r_state == S_RUN) && (r_occ != 2'd0) && !bus.stall_in && !r_finish;
    w_word_last  = (r_ch == CH_LAST) && (r_rep == REP_LAST);
    w_release    = w_emit && w_word_last;
    w_occ_next   = r_occ + {1'b0, w_accept} - {1'b0, w_release};
    w_state_next = r_state;
    if (r_finish) begin
      w_state_next = S_IDLE;
    end else if ((r_state == S_IDLE) && en) begin
      w_state_next = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
      r_ch          <= '0;
      r_rep         <= '0;
      r_frame       <= '0;
      r_finish      <= 1'b0;
      r_pixel_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_valid       <= 1'b0;
      r_data        <= '0;
      r_channel     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_occ         <= w_occ_next;
      r_pixel_ready <= (w_state_next == S_RUN) && (w_occ_next != 2'd2);
      r_busy        <= (w_state_next == S_RUN);
      r_done        <= r_finish;
      r_finish      <= w_release && (r_frame == PIX_LAST);
      r_valid       <= w_emit;
      if (w_accept) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_emit) begin
        r_data    <= w_word[r_ch];
        r_channel <= r_ch;
        if (w_word_last) begin
          r_rep    <= '0;
          r_ch     <= '0;
          r_rd_ptr <= ~r_rd_ptr;
          r_frame  <= (r_frame == PIX_LAST) ? '0 : r_frame + FW'(1);
        end else if (r_rep == REP_LAST) begin
          r_rep <= '0;
          r_ch  <= r_ch + CW'(1);
        end else begin
          r_rep <= r_rep + RW'(1);
        end
      end
    end
  end

`ifdef PW_STREAMER_LAST_EN
  logic r_last;
  logic r_frame_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= 1'b0;
      r_frame_last <= 1'b0;
    end else begin
      r_last       <= w_release;
      r_frame_last <= w_release && (r_frame == PIX_LAST);
    end
  end

  assign bus.last_out       = r_last;
  assign bus.frame_last_out = r_frame_last;
`endif

  assign bus.pixel_ready = r_pixel_ready;
  assign bus.data_out    = r_data;
  assign bus.channel_out = r_channel;
  assign bus.valid_out   = r_valid;
  assign busy            = r_busy;
  assign done            = r_done;
endmodule

// File: tb/tb_pw_feature_streamer.sv
// Directed bench for pw_feature_streamer (IN_CHANNELS=4, N=16, FEATURE_SIZE=2).
// dut1 runs with REPEAT=1, dut2 with REPEAT=2.
module tb_pw_feature_streamer;
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic en2;
  logic busy;
  logic done;
  logic busy2;
  logic done2;
  int   total = 0;
  int   bad   = 0;

  pw_feature_streamer_if #(.N(16), .IN_CHANNELS(4)) bus1 ();
  pw_feature_streamer_if #(.N(16), .IN_CHANNELS(4)) bus2 ();

  pw_feature_streamer #(.N(16), .IN_CHANNELS(4), .FEATURE_SIZE(2), .REPEAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .bus(bus1.slave), .busy(busy), .done(done)
  );
  pw_feature_streamer #(.N(16), .IN_CHANNELS(4), .FEATURE_SIZE(2), .REPEAT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .bus(bus2.slave), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel k carries channel c = k*16 + c + 1.
  function automatic logic [63:0] frame_pix(input int k);
    logic [63:0] p;
    for (int c = 0; c < 4; c++) p[c*16 +: 16] = 16'(k*16 + c + 1);
    return p;
  endfunction

  initial begin
    int idx, nvalid, ndone, rdrop, gap, done_cyc, last_cyc, nv, nready;
    logic acc;
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    bus1.pixel_in = '0; bus1.pixel_valid = 1'b0; bus1.stall_in = 1'b0;
    bus2.pixel_in = '0; bus2.pixel_valid = 1'b0; bus2.stall_in = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus1.valid_out, 0);
    chk("rst_data", bus1.data_out, 0);
    chk("rst_ch", bus1.channel_out, 0);
    chk("rst_ready", bus1.pixel_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef PW_STREAMER_LAST_EN
    chk("rst_last", bus1.last_out, 0);
    chk("rst_flast", bus1.frame_last_out, 0);
`endif
    rst = 1'b0;

    // Basic stream
    en = 1'b1; tick(); en = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_ready", bus1.pixel_ready, 1);
    bus1.pixel_in = 64'h0004_0003_0002_0001; bus1.pixel_valid = 1'b1;
    tick();
    bus1.pixel_valid = 1'b0;
    chk("basic_latency", bus1.valid_out, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("basic_v%0d", c), bus1.valid_out, 1);
      chk($sformatf("basic_ch%0d", c), bus1.channel_out, c);
      chk($sformatf("basic_d%0d", c), bus1.data_out, c + 1);
    end
    tick();
    chk("empty_valid", bus1.valid_out, 0);
    chk("empty_hold_data", bus1.data_out, 4);
    chk("empty_hold_ch", bus1.channel_out, 3);

    // Full frame, back-to-back
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    idx = 0; nvalid = 0; ndone = 0; rdrop = 0; gap = 0; done_cyc = -1; last_cyc = -1;
    bus1.pixel_in = frame_pix(0); bus1.pixel_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = bus1.pixel_valid && bus1.pixel_ready;
      tick();
      if (acc) idx++;
      bus1.pixel_valid = (idx < 4);
      bus1.pixel_in = frame_pix(idx);
      if (!bus1.pixel_ready && idx < 4) rdrop = 1;
      if (bus1.valid_out) begin
        if (nvalid > 0 && cyc != last_cyc + 1) gap++;
        chk($sformatf("frame_ch%0d", nvalid), bus1.channel_out, nvalid % 4);
        chk($sformatf("frame_d%0d", nvalid), bus1.data_out, (nvalid / 4) * 16 + (nvalid % 4) + 1);
`ifdef PW_STREAMER_LAST_EN
        chk($sformatf("frame_last%0d", nvalid), bus1.last_out, (nvalid % 4) == 3);
        chk($sformatf("frame_flast%0d", nvalid), bus1.frame_last_out, nvalid == 15);
`endif
        last_cyc = cyc;
        nvalid++;
      end
`ifdef PW_STREAMER_LAST_EN
      else begin
        chk("idle_last", bus1.last_out, 0);
        chk("idle_flast", bus1.frame_last_out, 0);
      end
`endif
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    chk("frame_words", nvalid, 16);
    chk("frame_gaps", gap, 0);
    chk("frame_ready_drop", rdrop, 1);
    chk("frame_done_once", ndone, 1);
    chk("frame_done_timing", done_cyc, last_cyc + 1);
    chk("frame_busy_after", busy, 0);

    // Stall after ch1
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    bus1.pixel_in = 64'h0044_0033_0022_0011; bus1.pixel_valid = 1'b1;
    tick();
    bus1.pixel_valid = 1'b0;
    tick();
    chk("stall_ch0", bus1.channel_out, 0);
    tick();
    chk("stall_ch1_v", bus1.valid_out, 1);
    chk("stall_ch1_d", bus1.data_out, 16'h0022);
    bus1.stall_in = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall_gap%0d", s), bus1.valid_out, 0);
    end
    bus1.stall_in = 1'b0;
    tick();
    chk("stall_ch2_v", bus1.valid_out, 1);
    chk("stall_ch2_ch", bus1.channel_out, 2);
    chk("stall_ch2_d", bus1.data_out, 16'h0033);
    tick();
    chk("stall_ch3_ch", bus1.channel_out, 3);
    chk("stall_ch3_d", bus1.data_out, 16'h0044);
    tick();
    chk("stall_end", bus1.valid_out, 0);

    // REPEAT=2 on dut2
    rst = 1'b1; tick(); rst = 1'b0;
    en2 = 1'b1; tick(); en2 = 1'b0;
    chk("rep_busy", busy2, 1);
    bus2.pixel_in = 64'h0008_0007_0006_0005; bus2.pixel_valid = 1'b1;
    tick();
    bus2.pixel_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rep_v%0d", i), bus2.valid_out, 1);
      chk($sformatf("rep_ch%0d", i), bus2.channel_out, i / 2);
      chk($sformatf("rep_d%0d", i), bus2.data_out, 5 + i / 2);
    end
    tick();
    chk("rep_end", bus2.valid_out, 0);
    chk("rep_nodone", done2, 0);

    // Reset mid-frame
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    bus1.pixel_in = frame_pix(0); bus1.pixel_valid = 1'b1;
    tick();
    bus1.pixel_in = frame_pix(1);
    tick();
    bus1.pixel_valid = 1'b0;
    nv = bus1.valid_out ? 1 : 0;
    for (int cyc = 0; cyc < 20 && nv < 5; cyc++) begin
      tick();
      if (bus1.valid_out) nv++;
    end
    chk("mid_words_before_rst", nv, 5);
    rst = 1'b1; tick();
    chk("mid_rst_valid", bus1.valid_out, 0);
    chk("mid_rst_data", bus1.data_out, 0);
    chk("mid_rst_ch", bus1.channel_out, 0);
    chk("mid_rst_ready", bus1.pixel_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    bus1.pixel_in = frame_pix(3); bus1.pixel_valid = 1'b1;
    nv = 0; nready = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (bus1.valid_out) nv++;
      if (bus1.pixel_ready) nready++;
    end
    chk("mid_idle_valid", nv, 0);
    chk("mid_idle_ready", nready, 0);
    bus1.pixel_valid = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    bus1.pixel_in = frame_pix(2); bus1.pixel_valid = 1'b1;
    tick();
    bus1.pixel_valid = 1'b0;
    tick();
    chk("restart_v", bus1.valid_out, 1);
    chk("restart_ch", bus1.channel_out, 0);
    chk("restart_d", bus1.data_out, 16'h0021);
    tick();
    chk("restart_ch1_d", bus1.data_out, 16'h0022);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pw_feature_streamer.md
PW_FEATURE_STREAMER -- requirements
Module: pw_feature_streamer

Interface
REQ-001 SHALL provide parameters (name, default, meaning): N, 16, data word width; IN_CHANNELS, 16, channels per pixel; FEATURE_SIZE, 112, feature map side, FEATURE_SIZE*FEATURE_SIZE pixels per frame; REPEAT, 1, consecutive valid cycles emitted per channel word.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 Ports (name, direction, width, meaning):
- clk, input, 1, sole clock, rising edge
- rst, input, 1, synchronous active-high reset
- en, input, 1, frame start request, sampled only in IDLE
- pixel_in, input, IN_CHANNELS*N, packed pixel; channel c at bits [c*N +: N]
- pixel_valid, input, 1, pixel_in valid
- pixel_ready, output, 1, buffer slot free; accept = pixel_valid && pixel_ready
- stall_in, input, 1, downstream backpressure
- data_out, output, N, channel word
- channel_out, output, $clog2(IN_CHANNELS), channel index of data_out
- valid_out, output, 1, data_out/channel_out valid
- busy, output, 1, high in RUN
- done, output, 1, one-cycle frame-complete pulse

Function
REQ-004 SHALL implement states IDLE and RUN; IDLE->RUN on en=1; RUN->IDLE on the cycle after the last word of the last pixel of the frame has been emitted.
REQ-005 SHALL hold a two-entry ping-pong pixel buffer with a registered occupancy count of 0..2.
REQ-006 pixel_ready SHALL be 1 only in RUN with occupancy < 2, decoded from registered state only, with no same-cycle bypass; while full it stays 0 even on a cycle that frees a slot.
REQ-007 Accepted pixels SHALL be emitted in acceptance order.
- Words go out channel 0 first, ascending to IN_CHANNELS-1.
- Each word is emitted REPEAT times, giving IN_CHANNELS*REPEAT valid_out cycles per pixel.
REQ-008 All outputs SHALL be registered.
- Pixel accepted at edge t into an empty buffer: its first word appears with valid_out=1 after edge t+1.
REQ-009 stall_in=1 sampled at an edge SHALL leave the read position unchanged and register valid_out=0; emission resumes with the same word after stall_in falls.
REQ-010 When a pixel's final word is emitted, that slot SHALL be freed at the same edge. If the other slot is occupied and stall_in=0, its channel 0 follows on the next cycle with no bubble.
REQ-011 Simultaneous accept and slot release SHALL leave occupancy unchanged, and no pixel is lost or duplicated.
REQ-012 A frame counter of width $clog2(FEATURE_SIZE*FEATURE_SIZE) SHALL count emitted pixels.
- After the last word of pixel FEATURE_SIZE*FEATURE_SIZE-1, done=1 for exactly one cycle.
- At the same point the counter wraps to 0 and the state returns to IDLE.
REQ-013 en SHALL be ignored while in RUN; pixels offered in IDLE SHALL not be accepted.
REQ-014 With an empty buffer, valid_out SHALL remain 0, and data_out/channel_out SHALL hold their last values.
REQ-015 busy SHALL equal (state == RUN).

Reset
REQ-016 rst=1 at an edge SHALL force all of the following, regardless of state:
- state=IDLE and occupancy=0
- frame and channel counters 0
- data_out=0, channel_out=0, valid_out=0, done=0, busy=0, pixel_ready=0
REQ-017 Reset mid-frame SHALL discard buffered pixels, and no valid_out SHALL be produced until a new en.

Configuration
REQ-018 Macro PW_STREAMER_LAST_EN: when defined, the module SHALL add output ports last_out (1) and frame_last_out (1).
- last_out is high with the final emitted word of each pixel, i.e. channel IN_CHANNELS-1 on its last repeat.
- frame_last_out is high on that word for the final pixel of the frame.
- Both are 0 after reset and 0 whenever valid_out=0.
REQ-019 Without PW_STREAMER_LAST_EN, last_out and frame_last_out SHALL be absent, and all other behaviour SHALL be identical.

Verification (parameters IN_CHANNELS=4, N=16, FEATURE_SIZE=2, REPEAT=1 unless stated)
REQ-020 Basic stream: en pulse, then pixel 0x0004_0003_0002_0001 offered -> after 1 cycle, valid_out for 4 cycles with (ch,data) = (0,1),(1,2),(2,3),(3,4).
REQ-021 Full frame back-to-back: 4 pixels offered with pixel_valid held high -> 16 contiguous valid cycles.
- pixel_ready drops while both slots are occupied.
- done=1 exactly once, one cycle after the 16th word.
- busy=0 afterwards.
REQ-022 Stall: stall_in=1 for 3 cycles after word ch1 -> valid_out=0 for 3 cycles, then ch2 resumes; no word skipped or duplicated.
REQ-023 REPEAT=2: one pixel -> 8 valid cycles with channel_out sequence 0,0,1,1,2,2,3,3.
REQ-024 Reset mid-frame: rst after 5 words -> outputs match REQ-016 on the next cycle; with en=0, no valid_out for 20 cycles; a new en plus a pixel restarts at ch0.
REQ-025 With PW_STREAMER_LAST_EN defined: last_out=1 on words 4, 8, 12 and 16; frame_last_out=1 on word 16 only.
